// File: rtl/exe_muldiv_unit.sv
// Iterative 32-bit multiply/divide unit for the EXE stage.
// Produces HI/LO 33 cycles after start and stalls the pipeline while it works.
module exe_muldiv_unit #(
    parameter logic [31:0] HILO_RST = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic        flush,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] mt_data,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state;
    logic        is_div;
    logic        sign_a;
    logic        sign_b;
    logic        b_zero;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [4:0]  cnt;
    logic [63:0] acc;

    logic        in_signed;
    logic        in_sa;
    logic        in_sb;
    logic        in_div;
    logic [31:0] in_mag_a;
    logic [31:0] in_mag_b;

    assign in_signed = (op == OP_MULT) || (op == OP_DIV);
    assign in_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign in_sa     = in_signed & rs_data[31];
    assign in_sb     = in_signed & rt_data[31];
    assign in_mag_a  = in_sa ? (32'd0 - rs_data) : rs_data;
    assign in_mag_b  = in_sb ? (32'd0 - rt_data) : rt_data;

    // Multiply: acc = {partial sum, remaining multiplier bits}
    logic [32:0] mul_sum;
    logic [63:0] mul_next;

    assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_a} : 33'd0);
    assign mul_next = {mul_sum, acc[31:1]};

    // Divide: acc = {partial remainder, dividend bits / quotient bits}
    logic [32:0] rem_sh;
    logic [33:0] trial;
    logic        take;
    logic [63:0] div_next;

    assign rem_sh   = acc[63:31];
    assign trial    = {1'b0, rem_sh} - {2'b00, mag_b};
    assign take     = ~trial[33];
    assign div_next = {take ? trial[31:0] : rem_sh[31:0], acc[30:0], take};

    logic        neg_res;
    logic [63:0] prod_s;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [31:0] raw_a;
    logic [31:0] fix_hi;
    logic [31:0] fix_lo;

    assign neg_res = sign_a ^ sign_b;
    assign prod_s  = neg_res ? (64'd0 - acc) : acc;
    assign quo_s   = neg_res ? (32'd0 - acc[31:0]) : acc[31:0];
    assign rem_s   = sign_a ? (32'd0 - acc[63:32]) : acc[63:32];
    assign raw_a   = sign_a ? (32'd0 - mag_a) : mag_a;

    // Divide by zero reports all-ones quotient and the original dividend
    assign fix_hi = !is_div ? prod_s[63:32] : (b_zero ? raw_a : rem_s);
    assign fix_lo = !is_div ? prod_s[31:0] : (b_zero ? 32'hFFFF_FFFF : quo_s);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= HILO_RST;
            lo       <= HILO_RST;
            cnt      <= 5'd0;
            is_div   <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            b_zero   <= 1'b0;
            mag_a    <= 32'd0;
            mag_b    <= 32'd0;
            acc      <= 64'd0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            if (flush) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            is_div <= in_div;
                            sign_a <= in_sa;
                            sign_b <= in_sb;
                            b_zero <= (rt_data == 32'd0);
                            mag_a  <= in_mag_a;
                            mag_b  <= in_mag_b;
                            acc    <= {32'd0, in_div ? in_mag_a : in_mag_b};
                            cnt    <= 5'd0;
                            busy   <= 1'b1;
                            state  <= CALC;
                        end else begin
                            if (mthi) hi <= mt_data;
                            if (mtlo) lo <= mt_data;
                        end
                    end
                    CALC: begin
                        acc <= is_div ? div_next : mul_next;
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) state <= FIX;
                    end
                    FIX: begin
                        hi       <= fix_hi;
                        lo       <= fix_lo;
                        done     <= 1'b1;
                        div_zero <= is_div & b_zero;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Scoreboard bench for exe_muldiv_unit: directed mult/div vectors,
// mthi/mtlo, ignored start, flush and mid-operation reset.
module tb_exe_muldiv_unit;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        Clk;
    logic        Rst;
    logic        start;
    logic [1:0]  op;
    logic        flush;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        mthi;
    logic        mtlo;
    logic [31:0] mt_data;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    exe_muldiv_unit dut (
        .Clk(Clk), .Rst(Rst), .start(start), .op(op), .flush(flush),
        .rs_data(rs_data), .rt_data(rt_data),
        .mthi(mthi), .mtlo(mtlo), .mt_data(mt_data),
        .busy(busy), .done(done), .div_zero(div_zero),
        .hi(hi), .lo(lo)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_done = 0;
    int   n_exp = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: hi=%h lo=%h", hi, lo);
            end else begin
                mon_e = sb.pop_front();
                chk("result_hi", {32'd0, hi}, {32'd0, mon_e.hi});
                chk("result_lo", {32'd0, lo}, {32'd0, mon_e.lo});
                chk("div_zero", {63'd0, div_zero}, {63'd0, mon_e.dz});
            end
        end
    end

    task automatic push(input logic [31:0] eh, input logic [31:0] el,
                        input logic ed);
        exp_t e;
        e.hi = eh;
        e.lo = el;
        e.dz = ed;
        sb.push_back(e);
        n_exp++;
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b);
        @(posedge Clk);
        #1;
        start = 1'b1;
        op = o;
        rs_data = a;
        rt_data = b;
        @(posedge Clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_busy);
        int n;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (busy === 1'b1) n++;
            else break;
        end
        chk(name, 64'(n), 64'(exp_busy));
    endtask

    task automatic run(input string name, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el,
                       input logic ed);
        push(eh, el, ed);
        launch(o, a, b);
        wait_done(name, 33);
    endtask

    int saved_done;

    initial begin
        Rst = 1'b1;
        start = 1'b0;
        op = OP_MULT;
        flush = 1'b0;
        rs_data = 32'd0;
        rt_data = 32'd0;
        mthi = 1'b0;
        mtlo = 1'b0;
        mt_data = 32'd0;
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;
        @(negedge Clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_dz", {63'd0, div_zero}, 64'd0);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);

        run("mult_7_m3", OP_MULT, 32'd7, 32'hFFFF_FFFD,
            32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run("mult_m1_m1", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            32'h0000_0000, 32'h0000_0001, 1'b0);
        run("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2,
            32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE,
            32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        run("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
            32'h0000_0000, 32'h8000_0000, 1'b0);
        run("div_m5_0", OP_DIV, 32'hFFFF_FFFB, 32'd0,
            32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
        run("divu_10_0", OP_DIVU, 32'd10, 32'd0,
            32'h0000_000A, 32'hFFFF_FFFF, 1'b1);
        run("divu_100_7", OP_DIVU, 32'd100, 32'd7,
            32'd2, 32'd14, 1'b0);

        @(posedge Clk);
        #1;
        mthi = 1'b1;
        mt_data = 32'h1234_5678;
        @(posedge Clk);
        #1;
        mthi = 1'b0;
        @(negedge Clk);
        chk("mthi_hi", {32'd0, hi}, 64'h1234_5678);
        chk("mthi_lo", {32'd0, lo}, 64'd14);

        push(32'd0, 32'd12, 1'b0);
        launch(OP_MULT, 32'd3, 32'd4);
        repeat (9) @(posedge Clk);
        #1;
        start = 1'b1;
        op = OP_MULT;
        rs_data = 32'd5;
        rt_data = 32'd5;
        mtlo = 1'b1;
        mt_data = 32'hFFFF_0000;
        @(posedge Clk);
        #1;
        start = 1'b0;
        mtlo = 1'b0;
        chk("busy_mtlo_lo", {32'd0, lo}, 64'd14);
        chk("busy_hi_hold", {32'd0, hi}, 64'h1234_5678);
        wait_done("mult_ignored_start", 23);

        @(posedge Clk);
        #1;
        mthi = 1'b1;
        mtlo = 1'b1;
        mt_data = 32'hA5A5_A5A5;
        @(posedge Clk);
        #1;
        mthi = 1'b0;
        mtlo = 1'b0;
        saved_done = n_done;
        launch(OP_DIVU, 32'd1000, 32'd3);
        repeat (9) @(posedge Clk);
        #1;
        flush = 1'b1;
        @(posedge Clk);
        #1;
        flush = 1'b0;
        @(negedge Clk);
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_hi", {32'd0, hi}, 64'hA5A5_A5A5);
        chk("flush_lo", {32'd0, lo}, 64'hA5A5_A5A5);
        repeat (40) @(negedge Clk);
        chk("flush_no_done", 64'(n_done), 64'(saved_done));

        launch(OP_DIVU, 32'd1000, 32'd3);
        repeat (19) @(posedge Clk);
        #1;
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        @(negedge Clk);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_hi", {32'd0, hi}, 64'd0);
        chk("midrst_lo", {32'd0, lo}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        repeat (40) @(negedge Clk);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("done_count", 64'(n_done), 64'(n_exp));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
